// File: rtl/spi_cmd_tx_reader_if.sv
// Command/read handshake bundle for spi_cmd_tx_reader.
// master: command processor plus memory responder side; slave: the transmit reader.
interface spi_cmd_tx_reader_if #(
    parameter int WORD_W = 32
);
    logic              cmd_send;
    logic [31:0]       region_end;
    logic              cmd_done;
    logic [31:0]       rd_ptr;
    logic              rd_r_en;
    logic              rd_done;
    logic [WORD_W-1:0] rd_data;

    modport master (
        output cmd_send, region_end, rd_done, rd_data,
        input  cmd_done, rd_ptr, rd_r_en
    );

    modport slave (
        input  cmd_send, region_end, rd_done, rd_data,
        output cmd_done, rd_ptr, rd_r_en
    );
endinterface

// File: rtl/spi_cmd_tx_reader.sv
// spi_cmd_tx_reader: drains a command region word by word through the read handshake
// and shifts each word out MSB-first on MISO as an SPI mode-0 slave.
// Optional build macro TX_PREFETCH_EN: fetch the next word into a holding register
// while the current one shifts, so back-to-back words need no inter-word gap.
//
// state | meaning
// IDLE  | waiting for cmd_send
// FETCH | read request for word idx outstanding
// LOAD  | word captured, MSB being presented on MISO
// SHIFT | word being clocked out by the master
module spi_cmd_tx_reader #(
    parameter int WORD_W      = 32,
    parameter int MAX_WORDS   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_L,
    spi_cmd_tx_reader_if.slave     bus,
    input  logic                   spi_sclk,
    input  logic                   spi_cs_n,
    output logic                   spi_miso,
    output logic                   spi_miso_oe,
    output logic                   busy,
    output logic                   underrun
);
    localparam int IDX_W = $clog2(MAX_WORDS);
    localparam int CNT_W = $clog2(MAX_WORDS + 1);
    localparam int BC_W  = $clog2(WORD_W + 1);
    localparam logic [BC_W-1:0] BC_FULL = BC_W'(WORD_W);

    typedef enum logic [1:0] {IDLE, FETCH, LOAD, SHIFT} state_t;

    state_t                   state;
    logic [SYNC_STAGES-1:0]   sclk_sync;
    logic [SYNC_STAGES-1:0]   cs_sync;
    logic                     sclk_d;
    logic                     cs_d;
    logic [WORD_W-1:0]        shreg;
    logic [WORD_W-1:0]        word_q;
    logic [BC_W-1:0]          bitcnt;
    logic [IDX_W-1:0]         idx;
    logic [IDX_W-1:0]         ptr_q;
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         cnt_in;
    logic [CNT_W-1:0]         idx_nxt;
    logic                     sclk_s;
    logic                     cs_s;
    logic                     sclk_rise;
    logic                     sclk_fall;
    logic                     cs_fall;
    logic                     rd_ack;
`ifdef TX_PREFETCH_EN
    logic [WORD_W-1:0]        hold_q;
    logic                     pf_valid;
    logic                     pf_hit;
    logic [WORD_W-1:0]        pf_word;
`endif

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    // sclk edges only count while the master has us selected
    assign sclk_rise = sclk_s & ~sclk_d & ~cs_s;
    assign sclk_fall = ~sclk_s & sclk_d & ~cs_s;
    assign cs_fall   = ~cs_s & cs_d;
    assign rd_ack    = bus.rd_r_en & bus.rd_done;
    assign cnt_in    = (bus.region_end > 32'(MAX_WORDS)) ? CNT_W'(MAX_WORDS)
                                                         : bus.region_end[CNT_W-1:0];
    assign idx_nxt   = CNT_W'(idx) + CNT_W'(1);
    assign bus.rd_ptr = 32'(ptr_q);
`ifdef TX_PREFETCH_EN
    assign pf_hit  = pf_valid | rd_ack;
    assign pf_word = pf_valid ? hold_q : bus.rd_data;
`endif

    // Synchronise the asynchronous SPI pins and keep one delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            sclk_sync   <= '0;
            cs_sync     <= '1;
            sclk_d      <= 1'b0;
            cs_d        <= 1'b1;
            spi_miso_oe <= 1'b0;
        end else begin
            sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            cs_sync     <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            sclk_d      <= sclk_s;
            cs_d        <= cs_s;
            spi_miso_oe <= ~cs_s;
        end
    end

    // Transfer sequencer: fetch, load and shift each word of the region
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state        <= IDLE;
            bus.cmd_done <= 1'b0;
            bus.rd_r_en  <= 1'b0;
            ptr_q        <= '0;
            spi_miso     <= 1'b0;
            busy         <= 1'b0;
            underrun     <= 1'b0;
            shreg        <= '0;
            word_q       <= '0;
            bitcnt       <= '0;
            idx          <= '0;
            cnt          <= '0;
`ifdef TX_PREFETCH_EN
            hold_q       <= '0;
            pf_valid     <= 1'b0;
`endif
        end else begin
            bus.cmd_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_send) begin
                        cnt      <= cnt_in;
                        idx      <= '0;
                        underrun <= 1'b0;
                        if (cnt_in == '0) begin
                            bus.cmd_done <= 1'b1;
                        end else begin
                            state       <= FETCH;
                            busy        <= 1'b1;
                            ptr_q       <= '0;
                            bus.rd_r_en <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (rd_ack) begin
                        shreg       <= bus.rd_data;
                        word_q      <= bus.rd_data;
                        bus.rd_r_en <= 1'b0;
                        bitcnt      <= '0;
                        state       <= LOAD;
                    end
                    if (sclk_rise) begin
                        spi_miso <= 1'b0;
                        underrun <= 1'b1;
                    end
                end
                LOAD: begin
                    state    <= SHIFT;
                    spi_miso <= sclk_rise ? 1'b0 : shreg[WORD_W-1];
                    if (sclk_rise) begin
                        underrun <= 1'b1;
                    end
                end
                SHIFT: begin
`ifdef TX_PREFETCH_EN
                    // keep at most one read in flight, for the word after this one
                    if (rd_ack) begin
                        hold_q      <= bus.rd_data;
                        pf_valid    <= 1'b1;
                        bus.rd_r_en <= 1'b0;
                    end else if (!pf_valid && !bus.rd_r_en && idx_nxt < cnt) begin
                        bus.rd_r_en <= 1'b1;
                        ptr_q       <= idx_nxt[IDX_W-1:0];
                    end
`endif
                    if (cs_s) begin
                        // deselected: rewind so the word restarts from its MSB
                        bitcnt <= '0;
                        shreg  <= word_q;
                    end else if (bitcnt == BC_FULL) begin
                        if (idx_nxt < cnt) begin
                            idx <= idx_nxt[IDX_W-1:0];
`ifdef TX_PREFETCH_EN
                            if (pf_hit) begin
                                shreg       <= pf_word;
                                word_q      <= pf_word;
                                spi_miso    <= pf_word[WORD_W-1];
                                bitcnt      <= '0;
                                pf_valid    <= 1'b0;
                                bus.rd_r_en <= 1'b0;
                            end else begin
                                state       <= FETCH;
                                bus.rd_r_en <= 1'b1;
                                ptr_q       <= idx_nxt[IDX_W-1:0];
                            end
`else
                            state       <= FETCH;
                            bus.rd_r_en <= 1'b1;
                            ptr_q       <= idx_nxt[IDX_W-1:0];
`endif
                        end else begin
                            bus.cmd_done <= 1'b1;
                            busy         <= 1'b0;
                            state        <= IDLE;
                        end
                    end else begin
                        if (cs_fall) begin
                            spi_miso <= shreg[WORD_W-1];
                        end
                        if (sclk_rise) begin
                            bitcnt <= bitcnt + BC_W'(1);
                        end
                        // a falling edge before any rising edge of this word consumed no bit
                        if (sclk_fall && bitcnt != '0) begin
                            shreg    <= shreg << 1;
                            spi_miso <= shreg[WORD_W-2];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
